// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - opcode constants and immediate format codes for the decode stage
package imm_decode_stage_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'h03;
  localparam logic [6:0] OPC_OP_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC     = 7'h17;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
  localparam logic [6:0] OPC_STORE     = 7'h23;
  localparam logic [6:0] OPC_LUI       = 7'h37;
  localparam logic [6:0] OPC_BRANCH    = 7'h63;
  localparam logic [6:0] OPC_JALR      = 7'h67;
  localparam logic [6:0] OPC_JAL       = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM    = 7'h73;

  // funct3[2] of a SYSTEM instruction selects the CSR immediate (zimm) forms
  localparam int FUNCT3_ZIMM_BIT = 14;

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational RV32I/RV64I immediate extraction and format classification
module imm_extract
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_fmt,
  output logic            o_no_imm
);

  logic signed [31:0] w_imm32;
  imm_fmt_e           w_fmt;

  always_comb begin
    w_imm32  = '0;
    w_fmt    = FMT_NONE;
    o_no_imm = 1'b0;
    case (i_instr[6:0])
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        w_fmt   = FMT_I;
      end
      OPC_STORE: begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        w_fmt   = FMT_S;
      end
      OPC_BRANCH: begin
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        w_fmt   = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        w_imm32 = {i_instr[31:12], 12'b0};
        w_fmt   = FMT_U;
      end
      OPC_JAL: begin
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
        w_fmt   = FMT_J;
      end
      OPC_SYSTEM: begin
        if (i_instr[FUNCT3_ZIMM_BIT]) begin
          w_imm32 = {27'b0, i_instr[19:15]};
          w_fmt   = FMT_Z;
        end else begin
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          w_fmt   = FMT_I;
        end
      end
      default: begin
        o_no_imm = 1'b1;
      end
    endcase
  end

  // Widening a signed 32-bit value sign-fills the upper half when XLEN is 64
  assign o_imm     = XLEN'(w_imm32);
  assign o_imm_fmt = w_fmt;

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - pipelined immediate decode stage with main register plus skid entry
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       imm_fmt,
  output logic             no_imm,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_no_imm;
  logic            w_accept;
  logic            w_drain;

  logic             r_main_valid;
  logic [XLEN-1:0]  r_main_imm;
  logic [2:0]       r_main_fmt;
  logic             r_main_no_imm;
  logic [TAG_W-1:0] r_main_tag;

  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [2:0]       r_skid_fmt;
  logic             r_skid_no_imm;
  logic [TAG_W-1:0] r_skid_tag;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .i_instr   (instr),
    .o_imm     (w_imm),
    .o_imm_fmt (w_fmt),
    .o_no_imm  (w_no_imm)
  );

  // in_ready is the inverted skid flag, so it never depends on out_ready this cycle
  assign w_accept = in_valid & ~r_skid_valid;
  assign w_drain  = r_main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid  <= 1'b0;
      r_main_imm    <= '0;
      r_main_fmt    <= '0;
      r_main_no_imm <= 1'b0;
      r_main_tag    <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_imm    <= '0;
      r_skid_fmt    <= '0;
      r_skid_no_imm <= 1'b0;
      r_skid_tag    <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_drain && r_skid_valid) begin
      r_main_valid  <= 1'b1;
      r_main_imm    <= r_skid_imm;
      r_main_fmt    <= r_skid_fmt;
      r_main_no_imm <= r_skid_no_imm;
      r_main_tag    <= r_skid_tag;
      r_skid_valid  <= 1'b0;
    end else if (w_accept && (!r_main_valid || w_drain)) begin
      r_main_valid  <= 1'b1;
      r_main_imm    <= w_imm;
      r_main_fmt    <= w_fmt;
      r_main_no_imm <= w_no_imm;
      r_main_tag    <= in_tag;
    end else if (w_accept) begin
      r_skid_valid  <= 1'b1;
      r_skid_imm    <= w_imm;
      r_skid_fmt    <= w_fmt;
      r_skid_no_imm <= w_no_imm;
      r_skid_tag    <= in_tag;
    end else if (w_drain) begin
      r_main_valid <= 1'b0;
    end
  end

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign imm       = r_main_imm;
  assign imm_fmt   = r_main_fmt;
  assign no_imm    = r_main_no_imm;
  assign out_tag   = r_main_tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench driving XLEN=32 and XLEN=64 stages in parallel
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] instr, in_tag;

  logic        a_in_ready, a_out_valid, a_no_imm;
  logic [31:0] a_imm, a_out_tag;
  logic [2:0]  a_fmt;

  logic        b_in_ready, b_out_valid, b_no_imm;
  logic [63:0] b_imm;
  logic [31:0] b_out_tag;
  logic [2:0]  b_fmt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm(a_imm), .imm_fmt(a_fmt), .no_imm(a_no_imm), .out_tag(a_out_tag)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .imm(b_imm), .imm_fmt(b_fmt), .no_imm(b_no_imm), .out_tag(b_out_tag)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer with an idle consumer; both widths checked against hand-computed values
  task automatic apply(input string name, input logic [31:0] ins, input logic [31:0] tag,
                       input logic [63:0] exp64, input logic [2:0] fmt, input logic noi);
    instr = ins; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({name, "_valid32"}, {63'd0, a_out_valid}, 64'd1);
    chk({name, "_imm32"},   {32'd0, a_imm}, {32'd0, exp64[31:0]});
    chk({name, "_fmt32"},   {61'd0, a_fmt}, {61'd0, fmt});
    chk({name, "_noimm32"}, {63'd0, a_no_imm}, {63'd0, noi});
    chk({name, "_tag32"},   {32'd0, a_out_tag}, {32'd0, tag});
    chk({name, "_valid64"}, {63'd0, b_out_valid}, 64'd1);
    chk({name, "_imm64"},   b_imm, exp64);
    chk({name, "_fmt64"},   {61'd0, b_fmt}, {61'd0, fmt});
  endtask

  int unsigned q[$];
  int unsigned next_tag;
  int unsigned rcv;
  bit acc, drn;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; in_tag = '0;
    tick(); tick();
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, a_in_ready}, 64'd1);
    chk("rst_imm",       {32'd0, a_imm}, 64'd0);
    chk("rst_fmt",       {61'd0, a_fmt}, 64'd0);
    chk("rst_no_imm",    {63'd0, a_no_imm}, 64'd0);
    chk("rst_out_tag",   {32'd0, a_out_tag}, 64'd0);
    chk("rst_imm64",     b_imm, 64'd0);
    rst = 1'b0;

    apply("addi",   32'hFFF00093, 32'h10, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0);
    apply("sw",     32'hFE20AE23, 32'h11, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0);
    apply("beq",    32'hFE000CE3, 32'h12, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0);
    apply("jal",    32'h001000EF, 32'h13, 64'h00000000_00000800, 3'd5, 1'b0);
    apply("lui",    32'h123452B7, 32'h14, 64'h00000000_12345000, 3'd4, 1'b0);
    apply("luineg", 32'h800002B7, 32'h15, 64'hFFFFFFFF_80000000, 3'd4, 1'b0);
    apply("csrrwi", 32'h340FD0F3, 32'h16, 64'h00000000_0000001F, 3'd6, 1'b0);
    apply("csrrw",  32'h34009073, 32'h17, 64'h00000000_00000340, 3'd1, 1'b0);
    apply("ld",     32'h8000B103, 32'h18, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0);
    apply("add",    32'h002081B3, 32'h19, 64'h00000000_00000000, 3'd0, 1'b1);
    out_ready = 1'b1;
    tick();

    // Streaming: eight back-to-back transfers appear on consecutive cycles in order
    for (int i = 0; i < 8; i++) begin
      instr = 32'h00100093 + (i << 20); in_tag = 100 + i; in_valid = 1'b1;
      tick();
      chk("stream_valid", {63'd0, a_out_valid}, 64'd1);
      chk("stream_tag",   {32'd0, a_out_tag}, 64'(100 + i));
      chk("stream_imm",   {32'd0, a_imm}, 64'(1 + i));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_idle", {63'd0, a_out_valid}, 64'd0);

    // Backpressure: consumer stalls 4 cycles; six tags must arrive once each, in order
    next_tag = 200; rcv = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (next_tag < 206);
      in_tag    = next_tag;
      instr     = 32'hFFF00093;
      if (cyc == 2) chk("bp_in_ready_low", {63'd0, a_in_ready}, 64'd0);
      if (cyc == 3) chk("bp_hold_tag", {32'd0, a_out_tag}, 64'd200);
      acc = in_valid && a_in_ready;
      drn = a_out_valid && out_ready;
      if (drn) begin
        if (q.size() == 0) chk("bp_unexpected_out", {32'd0, a_out_tag}, 64'hFFFFFFFF);
        else chk("bp_order", {32'd0, a_out_tag}, {32'd0, q.pop_front()});
        rcv++;
      end
      if (acc) q.push_back(next_tag);
      tick();
      if (acc) next_tag++;
    end
    in_valid = 1'b0;
    chk("bp_received", 64'(rcv), 64'd6);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);
    chk("bp_drained", {63'd0, a_out_valid}, 64'd0);

    // Flush with both entries occupied; the in-cycle input is dropped too
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 300; tick();
    in_tag = 301; tick();
    chk("fl_full", {63'd0, a_in_ready}, 64'd0);
    flush = 1'b1; in_tag = 302; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("fl_in_ready",  {63'd0, a_in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_no_stale", {63'd0, a_out_valid}, 64'd0);
    end

    // Reset with both entries occupied; in-flight tags are never delivered
    out_ready = 1'b0; in_valid = 1'b1;
    in_tag = 310; tick();
    in_tag = 311; tick();
    rst = 1'b1; flush = 1'b1; in_tag = 312; tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rs_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rs_in_ready",  {63'd0, a_in_ready}, 64'd1);
    chk("rs_out_tag",   {32'd0, a_out_tag}, 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rs_no_stale", {63'd0, a_out_valid}, 64'd0);
    end

    apply("post_rst", 32'h00500093, 32'd320, 64'd5, 3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
